flag_eval: RTL and testbench
============================

// Module: flag_eval
// PURPOSE
//   Consumer end of the adder's result/flag interface. Captures res/z/c/v into an
//   NZCV status register and answers branch-condition queries through a
//   valid/ready request/response handshake.
//   Sits between the ALU (add) and the branch/PC-select logic.
// PARAMETERS
//   W      32  operand/result width; N flag = res_in[W-1]
//   CNT_W  16  width of the saturating taken-branch counter
// PORTS
//   elk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   flag_we    in   1      capture res_in/z_in/c_in/v_in into NZCV this edge
//   res_in     in   W      ALU result (sign bit -> N)
//   z_in       in   1      ALU zero flag
//   c_in       in   1      ALU carry flag
//   v_in       in   1      ALU overflow flag
//   q_valid    in   1      condition query present
//   q_cond     in   4      condition code (see BEHAVIOUR)
//   q_ready    out  1      query accepted when q_valid & q_ready
//   r_valid    out  1      response held until r_ready
//   r_taken    out  1      condition result for the accepted query
//   r_ready    in   1      downstream accepts response
//   nzcv       out  4      current status register {N,Z,C,V}
//   taken_cnt  out  CNT_W  saturating count of responses with r_taken=1
//   so         out  1      sticky overflow (STICKY_OVF_EN only, else 0)
// BEHAVIOUR
//   Reset (rst=1 at edge): nzcv=0, r_valid=0, r_taken=0, taken_cnt=0, so=0; overrides all else.
//   Reset mid-transaction drops a pending response; no replay.
//   Flag capture: flag_we at edge T -> nzcv={res_in[W-1],z_in,c_in,v_in} after T.
//   z_in is taken as given; not recomputed from res_in.
//   Query: accepted at edge T -> r_valid=1, r_taken valid after T (latency 1).
//   q_ready = !r_valid | r_ready (single output register, full-throughput).
//   Back-to-back queries at one per clock are allowed while r_ready=1.
//   r_valid & !r_ready: r_taken and r_valid held stable; q_ready=0.
//   The response to a query is fixed at acceptance; a later flag_we never alters it.
//   Bypass: flag_we and query accepted in the same cycle -> evaluate against the NEW flags.
//   Cond codes (decided):
//     0 EQ Z | 1 NE !Z | 2 CS C | 3 CC !C | 4 MI N | 5 PL !N | 6 VS V | 7 VC !V
//     8 HI C&!Z | 9 LS !C|Z | A GE N==V | B LT N!=V | C GT !Z&(N==V)
//     D LE Z|(N!=V) | E AL 1 | F NV 0 (see CONFIGURATION)
//   taken_cnt: +1 on each accepted query evaluating taken; saturates at 2^CNT_W-1, no wrap.
//   flag_we with no query: no response is generated.
//   Query with no flag_we: evaluated against the held nzcv.
// CONFIGURATION
//   STICKY_OVF_EN defined:
//     so set on any edge with flag_we & v_in.
//     Cleared only by rst.
//     Cond F evaluates to so (with the same-cycle bypass).
//   STICKY_OVF_EN undefined:
//     so tied 0.
//     Cond F always 0.
// STRUCTURE
//   flag_pkg: COND_EQ..COND_NV localparams (4-bit); NZCV bit-index constants.
//   Sub-module cond_decode: combinational {nzcv,so,cond} -> taken; reused by branch unit.
//   flag_eval holds: nzcv register, output register/handshake, counter, sticky bit.
// TESTING
//   1 flag_we, res=0, z=1,c=0,v=0; next cycle query EQ -> r_taken=1, nzcv=4'b0100.
//   2 Same-cycle flag_we res=32'h8000_0000,v=0 + query LT -> r_taken=1 (bypass).
//     Query GE the next cycle -> r_taken=0.
//   3 r_ready=0 for 3 cycles after a response:
//     r_valid/r_taken stable, q_ready=0.
//     r_ready=1 -> next queued query accepted that edge.
//   4 CNT_W=4: 20 accepted AL queries -> taken_cnt saturates at 15.
//   5 rst asserted while r_valid=1, r_ready=0 -> r_valid=0, nzcv=0, taken_cnt=0 next cycle.
//   6 STICKY_OVF_EN: flag_we v=1 then v=0 -> so=1, cond F taken=1.
//     Build without the macro: so=0, cond F taken=0.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared constants for the NZCV status register and branch condition codes.
package flag_pkg;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_decode.sv
// Combinational branch-condition evaluator: {nzcv, so, cond} -> taken.
// Shared with the branch unit; NV reports the sticky-overflow input.
module cond_decode
  import flag_pkg::*;
(
  input  logic [3:0] nzcv_i,
  input  logic       so_i,
  input  logic [3:0] cond_i,
  output logic       taken_o
);

  logic n, z, c, v;

  assign n = nzcv_i[NZCV_N];
  assign z = nzcv_i[NZCV_Z];
  assign c = nzcv_i[NZCV_C];
  assign v = nzcv_i[NZCV_V];

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_CS: taken_o = c;
      COND_CC: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = c & !z;
      COND_LS: taken_o = !c | z;
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z & (n == v);
      COND_LE: taken_o = z | (n != v);
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = so_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_eval.sv
// NZCV status register with a one-deep valid/ready branch-condition query port.
// Optional sticky overflow bit enabled by defining STICKY_OVF_EN.
module flag_eval
  import flag_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             elk,
  input  logic             rst,
  input  logic             flag_we,
  input  logic [W-1:0]     res_in,
  input  logic             z_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             q_valid,
  input  logic [3:0]       q_cond,
  output logic             q_ready,
  output logic             r_valid,
  output logic             r_taken,
  input  logic             r_ready,
  output logic [3:0]       nzcv,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             so
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       nzcv_q, nzcv_d, nzcv_new, nzcv_eval;
  logic             r_valid_q, r_valid_d;
  logic             r_taken_q, r_taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             so_eval, taken, accept;
  logic             unused_res;

  // Only the sign bit of the result feeds a flag.
  assign unused_res = ^res_in[W-2:0];

  assign nzcv_new  = {res_in[W-1], z_in, c_in, v_in};
  // Same-cycle capture is visible to the query being accepted.
  assign nzcv_eval = flag_we ? nzcv_new : nzcv_q;
  assign q_ready   = !r_valid_q | r_ready;
  assign accept    = q_valid & q_ready;

`ifdef STICKY_OVF_EN
  logic so_q, so_d;

  assign so_d    = so_q | (flag_we & v_in);
  assign so_eval = so_d;
  assign so      = so_q;

  always_ff @(posedge elk) begin
    if (rst) so_q <= 1'b0;
    else     so_q <= so_d;
  end
`else
  assign so_eval = 1'b0;
  assign so      = 1'b0;
`endif

  cond_decode u_cond_decode (
    .nzcv_i  (nzcv_eval),
    .so_i    (so_eval),
    .cond_i  (q_cond),
    .taken_o (taken)
  );

  always_comb begin
    nzcv_d    = flag_we ? nzcv_new : nzcv_q;
    r_valid_d = r_valid_q;
    r_taken_d = r_taken_q;
    cnt_d     = cnt_q;
    if (accept) begin
      r_valid_d = 1'b1;
      r_taken_d = taken;
      if (taken && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge elk) begin
    if (rst) begin
      nzcv_q    <= '0;
      r_valid_q <= 1'b0;
      r_taken_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      nzcv_q    <= nzcv_d;
      r_valid_q <= r_valid_d;
      r_taken_q <= r_taken_d;
      cnt_q     <= cnt_d;
    end
  end

  assign nzcv      = nzcv_q;
  assign r_valid   = r_valid_q;
  assign r_taken   = r_taken_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_flag_eval.sv
// Directed self-checking bench for flag_eval (CNT_W=4 to reach saturation quickly).
// Sticky-overflow expectations follow whether STICKY_OVF_EN is defined.
module tb_flag_eval;
  import flag_pkg::*;

  localparam int W     = 32;
  localparam int CNT_W = 4;

  logic             elk = 1'b0;
  logic             rst;
  logic             flag_we;
  logic [W-1:0]     res_in;
  logic             z_in, c_in, v_in;
  logic             q_valid;
  logic [3:0]       q_cond;
  logic             q_ready;
  logic             r_valid;
  logic             r_taken;
  logic             r_ready;
  logic [3:0]       nzcv;
  logic [CNT_W-1:0] taken_cnt;
  logic             so;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] cnt_m;
  logic       so_m;

  flag_eval #(.W(W), .CNT_W(CNT_W)) dut (
    .elk       (elk),
    .rst       (rst),
    .flag_we   (flag_we),
    .res_in    (res_in),
    .z_in      (z_in),
    .c_in      (c_in),
    .v_in      (v_in),
    .q_valid   (q_valid),
    .q_cond    (q_cond),
    .q_ready   (q_ready),
    .r_valid   (r_valid),
    .r_taken   (r_taken),
    .r_ready   (r_ready),
    .nzcv      (nzcv),
    .taken_cnt (taken_cnt),
    .so        (so)
  );

  always #5 elk = ~elk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge elk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1;
    res_in  = {f[3], {(W-1){1'b0}}};
    z_in    = f[2];
    c_in    = f[1];
    v_in    = f[0];
    if (f[0]) so_m = 1'b1;
  endtask

  task automatic bump_cnt();
    if (cnt_m != 4'hF) cnt_m = cnt_m + 4'h1;
  endtask

  function automatic logic exp_taken(input logic [3:0] f, input logic s, input logic [3:0] cc);
    logic n, z, c, v, nv_val;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
`ifdef STICKY_OVF_EN
    nv_val = s;
`else
    nv_val = 1'b0;
`endif
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return nv_val;
    endcase
  endfunction

  function automatic logic exp_so(input logic s);
`ifdef STICKY_OVF_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic [3:0] sweep_flags [2];
    logic       e;
    sweep_flags[0] = 4'b1001;
    sweep_flags[1] = 4'b0110;

    rst = 1'b1; flag_we = 1'b0; res_in = '0; z_in = 1'b0; c_in = 1'b0; v_in = 1'b0;
    q_valid = 1'b0; q_cond = 4'h0; r_ready = 1'b1;
    cnt_m = 4'h0; so_m = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset nzcv", 32'(nzcv), 32'h0);
    check("reset r_valid", 32'(r_valid), 32'h0);
    check("reset r_taken", 32'(r_taken), 32'h0);
    check("reset taken_cnt", 32'(taken_cnt), 32'h0);
    check("reset so", 32'(so), 32'h0);
    check("reset q_ready", 32'(q_ready), 32'h1);

    // Capture Z=1, then query EQ against the held flags.
    set_flags(4'b0100);
    step();
    flag_we = 1'b0;
    check("t1 nzcv", 32'(nzcv), 32'h4);
    check("t1 no response", 32'(r_valid), 32'h0);
    q_valid = 1'b1; q_cond = COND_EQ;
    step();
    q_valid = 1'b0; bump_cnt();
    check("t1 r_valid", 32'(r_valid), 32'h1);
    check("t1 r_taken EQ", 32'(r_taken), 32'h1);
    check("t1 taken_cnt", 32'(taken_cnt), 32'(cnt_m));

    // Bypass: N=1,V=0 written and LT queried on the same edge.
    set_flags(4'b1000);
    q_valid = 1'b1; q_cond = COND_LT;
    step();
    flag_we = 1'b0; bump_cnt();
    check("t2 r_taken LT bypass", 32'(r_taken), 32'h1);
    check("t2 nzcv", 32'(nzcv), 32'h8);
    q_cond = COND_GE;
    step();
    q_valid = 1'b0;
    check("t2 r_taken GE", 32'(r_taken), 32'h0);
    check("t2 r_valid back-to-back", 32'(r_valid), 32'h1);
    check("t2 taken_cnt", 32'(taken_cnt), 32'(cnt_m));

    // Back-pressure: response held while flags change underneath it.
    q_valid = 1'b1; q_cond = COND_NE;
    step();
    bump_cnt();
    check("t3 r_taken NE", 32'(r_taken), 32'h1);
    r_ready = 1'b0;
    set_flags(4'b0100);
    #1;
    check("t3 q_ready stalled", 32'(q_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      flag_we = 1'b0;
      check("t3 r_valid held", 32'(r_valid), 32'h1);
      check("t3 r_taken held", 32'(r_taken), 32'h1);
      check("t3 q_ready low", 32'(q_ready), 32'h0);
    end
    check("t3 nzcv updated", 32'(nzcv), 32'h4);
    r_ready = 1'b1;
    #1;
    check("t3 q_ready released", 32'(q_ready), 32'h1);
    step();
    q_valid = 1'b0;
    check("t3 queued r_valid", 32'(r_valid), 32'h1);
    check("t3 queued r_taken NE", 32'(r_taken), 32'h0);
    step();
    check("t3 drained", 32'(r_valid), 32'h0);
    check("t3 taken_cnt", 32'(taken_cnt), 32'(cnt_m));

    // All sixteen codes against two flag patterns, one query per clock.
    for (int s = 0; s < 2; s++) begin
      set_flags(sweep_flags[s]);
      step();
      flag_we = 1'b0;
      for (int k = 0; k < 16; k++) begin
        q_valid = 1'b1; q_cond = 4'(k);
        step();
        e = exp_taken(sweep_flags[s], so_m, 4'(k));
        if (e) bump_cnt();
        check($sformatf("sweep f=%b c=%0h", sweep_flags[s], k), 32'(r_taken), 32'(e));
      end
      q_valid = 1'b0;
      check("sweep taken_cnt", 32'(taken_cnt), 32'(cnt_m));
      check("sweep so", 32'(so), 32'(exp_so(so_m)));
    end

    // Saturation from zero.
    rst = 1'b1;
    step();
    rst = 1'b0; cnt_m = 4'h0; so_m = 1'b0;
    for (int i = 0; i < 20; i++) begin
      q_valid = 1'b1; q_cond = COND_AL;
      step();
      bump_cnt();
      check($sformatf("sat cnt %0d", i), 32'(taken_cnt), 32'(cnt_m));
    end
    q_valid = 1'b0;
    check("sat final", 32'(taken_cnt), 32'd15);

    // Reset while a response is stalled.
    set_flags(4'b0110);
    q_valid = 1'b1; q_cond = COND_AL; r_ready = 1'b0;
    step();
    flag_we = 1'b0; q_valid = 1'b0;
    check("t5 r_valid pending", 32'(r_valid), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; cnt_m = 4'h0; so_m = 1'b0;
    check("t5 r_valid dropped", 32'(r_valid), 32'h0);
    check("t5 r_taken", 32'(r_taken), 32'h0);
    check("t5 nzcv", 32'(nzcv), 32'h0);
    check("t5 taken_cnt", 32'(taken_cnt), 32'h0);
    check("t5 so", 32'(so), 32'h0);
    r_ready = 1'b1;
    step();
    check("t5 no replay", 32'(r_valid), 32'h0);

    // Sticky overflow survives a later V=0 capture.
    set_flags(4'b0001);
    step();
    set_flags(4'b0000);
    step();
    flag_we = 1'b0;
    check("t6 nzcv", 32'(nzcv), 32'h0);
    check("t6 so", 32'(so), 32'(exp_so(so_m)));
    q_valid = 1'b1; q_cond = COND_NV;
    step();
    q_valid = 1'b0;
    check("t6 r_taken NV", 32'(r_taken), 32'(exp_taken(4'b0000, so_m, COND_NV)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
